// File: rtl/global_variables.sv
// Shared constants for the fetch front end: address width, instruction size
// and the default sizing of the program sequencer.
package global_variables;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int FETCH_WIDTH = 2;
    localparam int RAS_DEPTH   = 8;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and the count saturates. A push and a pop in the same cycle on a
// non-empty stack replace the top entry in place.
module return_address_stack #(
    parameter int XLEN  = global_variables::XLEN,
    parameter int DEPTH = global_variables::RAS_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [XLEN-1:0]  push_address,
    output logic [XLEN-1:0]  top,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [XLEN-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_r;
    logic [PTR_W-1:0] ptr_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic             wr_en_s;
    logic             has_entry_s;

    assign has_entry_s = (count_r != {CNT_W{1'b0}});
    assign top         = mem_r[ptr_r];
    assign empty       = empty_r;
    assign count       = count_r;

    // Work out pointer, count and entry write for this cycle's push/pop mix.
    always_comb begin
        ptr_next_s   = ptr_r;
        count_next_s = count_r;
        wr_idx_s     = ptr_r;
        wr_en_s      = 1'b0;
        if (push && pop && has_entry_s) begin
            wr_en_s  = 1'b1;
            wr_idx_s = ptr_r;
        end else if (pop && has_entry_s) begin
            ptr_next_s   = ptr_r - PTR_W'(1);
            count_next_s = count_r - CNT_W'(1);
        end else if (push) begin
            ptr_next_s = ptr_r + PTR_W'(1);
            wr_idx_s   = ptr_r + PTR_W'(1);
            wr_en_s    = 1'b1;
            if (count_r == CNT_W'(DEPTH)) begin
                count_next_s = count_r;
            end else begin
                count_next_s = count_r + CNT_W'(1);
            end
        end else begin
            ptr_next_s   = ptr_r;
            count_next_s = count_r;
        end
    end

    // Pointer, occupancy and empty flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r   <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            empty_r <= 1'b1;
        end else begin
            ptr_r   <= ptr_next_s;
            count_r <= count_next_s;
            empty_r <= (count_next_s == {CNT_W{1'b0}});
        end
    end

    // Entry storage; contents are left as-is across reset.
    always_ff @(posedge clock) begin
        if (wr_en_s && !reset) begin
            mem_r[wr_idx_s] <= push_address;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch address sequencer: reset vector, redirects, return-address-stack
// pops and linear advance of up to FETCH_WIDTH instructions per cycle.
module program_sequencer #(
    parameter int              XLEN         = global_variables::XLEN,
    parameter int              FETCH_WIDTH  = global_variables::FETCH_WIDTH,
    parameter int              RAS_DEPTH    = global_variables::RAS_DEPTH,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    localparam int ADV_W = $clog2(FETCH_WIDTH) + 1,
    localparam int CNT_W = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_address,
    input  logic [ADV_W-1:0] advance,
    input  logic             ras_push,
    input  logic [XLEN-1:0]  ras_push_address,
    input  logic             ras_pop,
    output logic [XLEN-1:0]  address,
    output logic             address_valid,
    output logic             misaligned,
    output logic             ras_underflow,
    output logic             ras_empty
);

    logic [XLEN-1:0]  address_r;
    logic             address_valid_r;
    logic             misaligned_r;
    logic             ras_underflow_r;
    logic [XLEN-1:0]  next_address_s;
    logic [ADV_W-1:0] adv_clamped_s;
    logic [XLEN-1:0]  ras_top_s;
    logic [CNT_W-1:0] ras_count_s;
    logic             ras_has_entry_s;
    logic             ras_empty_s;

    assign ras_has_entry_s = (ras_count_s != {CNT_W{1'b0}});

    return_address_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock        (clock),
        .reset        (reset),
        .push         (ras_push),
        .pop          (ras_pop),
        .push_address (ras_push_address),
        .top          (ras_top_s),
        .empty        (ras_empty_s),
        .count        (ras_count_s)
    );

    // Choose the next fetch address: redirect, then stack pop, then advance.
    always_comb begin
        next_address_s = address_r;
        if (advance > ADV_W'(FETCH_WIDTH)) begin
            adv_clamped_s = ADV_W'(FETCH_WIDTH);
        end else begin
            adv_clamped_s = advance;
        end
        if (redirect) begin
            next_address_s = {redirect_address[XLEN-1:2], 2'b00};
        end else if (ras_pop && ras_has_entry_s) begin
            next_address_s = ras_top_s;
        end else begin
            next_address_s = address_r
                + (XLEN'(adv_clamped_s) * XLEN'(global_variables::INSTR_BYTES));
        end
    end

    // Address register and one-cycle status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            address_r       <= RESET_VECTOR;
            address_valid_r <= 1'b0;
            misaligned_r    <= 1'b0;
            ras_underflow_r <= 1'b0;
        end else begin
            address_r       <= next_address_s;
            address_valid_r <= 1'b1;
            misaligned_r    <= redirect && (redirect_address[1:0] != 2'b00);
            ras_underflow_r <= ras_pop && !ras_has_entry_s;
        end
    end

    assign address       = address_r;
    assign address_valid = address_valid_r;
    assign misaligned    = misaligned_r;
    assign ras_underflow = ras_underflow_r;
    assign ras_empty     = ras_empty_s;

endmodule
